// File: rtl/n_clk_pkg.sv
// Shared constants, FSM state encoding and width helpers for the n_clk period measurement.
package n_clk_pkg;

  localparam int N_WIDTH_DEF = 14;
  localparam logic [N_WIDTH_DEF-1:0] N_CLK_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STALE = 2'd2
  } state_e;

  function automatic int avgSumWidth(input int nWidth, input int avgLog2);
    return nWidth + avgLog2;
  endfunction

endpackage

// File: rtl/n_clk_meas_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin plus a registered rising-edge pulse.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
      edge_q <= sync_q[STAGES-1] & ~dly_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/n_clk_meas.sv
// Measures the reference period in clk cycles and publishes it as n_clk with a strobe and stale flag.
// Build option: define N_CLK_AVG_EN to publish the mean of the last 2^AVG_LOG2 accepted periods.
module n_clk_meas
  import n_clk_pkg::*;
#(
  parameter int N_WIDTH     = N_WIDTH_DEF,
  parameter int MIN_PERIOD  = 16,
`ifdef N_CLK_AVG_EN
  parameter int AVG_LOG2    = 2,
`endif
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sig,
  output logic [N_WIDTH-1:0] n_clk,
  output logic               n_valid,
  output logic               stale
);

  localparam logic [N_WIDTH-1:0] NMAX = '1;
  localparam logic [N_WIDTH-1:0] MINP = N_WIDTH'(MIN_PERIOD);

  state_e             state_q;
  logic [N_WIDTH-1:0] cnt_q;
  logic [N_WIDTH-1:0] cnt_d;
  logic [N_WIDTH-1:0] n_clk_q;
  logic               n_valid_q;
  logic               stale_q;
  logic               edgePulse;
  logic               atMax;
  logic               accept;
  logic               goStale;
  logic               publish;
  logic [N_WIDTH-1:0] pubValue;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (sig),
    .edge_o  (edgePulse)
  );

  assign atMax   = (cnt_q == NMAX);
  assign accept  = edgePulse && (state_q == MEAS) && (cnt_q >= MINP);
  assign goStale = (state_q == MEAS) && atMax && !edgePulse;

  // Any edge outside MEAS only arms the counter; inside MEAS short edges are glitches.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (edgePulse && ((state_q != MEAS) || accept)) begin
      cnt_d = N_WIDTH'(1);
    end else if (atMax) begin
      cnt_d = NMAX;
    end
  end

`ifdef N_CLK_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = avgSumWidth(N_WIDTH, AVG_LOG2);
  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);

  logic [N_WIDTH-1:0] win_q [DEPTH];
  logic [SW-1:0]      sum_q;
  logic [SW-1:0]      sum_d;
  logic [AVG_LOG2:0]  fill_q;

  // Unfilled slots hold zero, so removing the oldest entry first can never underflow.
  assign sum_d    = (sum_q - SW'(win_q[DEPTH-1])) + SW'(cnt_q);
  assign publish  = accept && (fill_q >= FILL_LAST);
  assign pubValue = N_WIDTH'(sum_d >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (reset || goStale) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (accept) begin
      win_q[0] <= cnt_q;
      for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
      sum_q <= sum_d;
      if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
    end
  end
`else
  assign publish  = accept;
  assign pubValue = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_clk_q   <= NMAX;
      n_valid_q <= 1'b0;
      stale_q   <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      n_valid_q <= 1'b0;
      case (state_q)
        IDLE, STALE: begin
          if (edgePulse) state_q <= MEAS;
        end
        MEAS: begin
          if (publish) begin
            n_clk_q   <= pubValue;
            n_valid_q <= 1'b1;
            stale_q   <= 1'b0;
          end else if (goStale) begin
            state_q <= STALE;
            n_clk_q <= NMAX;
            stale_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign n_clk   = n_clk_q;
  assign n_valid = n_valid_q;
  assign stale   = stale_q;

endmodule

// File: tb/tb_n_clk_meas.sv
// Randomised scoreboard bench for n_clk_meas; the reference model works on sig rise times directly.
module tb_n_clk_meas;

  localparam int MAXV = 16383;
  localparam int MINP = 16;
  localparam int LAT  = 4;
`ifdef N_CLK_AVG_EN
  localparam int AVG_LOG2 = 2;
`endif

  typedef struct {
    int cyc;
    int nclk;
    bit st;
  } ev_t;

  typedef struct {
    int cyc;
    int val;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig = 1'b0;
  logic [13:0] n_clk;
  logic        n_valid;
  logic        stale;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t evQ[$];
  sb_t sbQ[$];
  int  win[$];
  bit  armed = 1'b0;
  int  lastRise = 0;
  int  expN = MAXV;
  bit  expS = 1'b1;
  bit  monOn = 1'b0;
  bit  due;

  n_clk_meas dut (
    .clk     (clk),
    .reset   (reset),
    .sig     (sig),
    .n_clk   (n_clk),
    .n_valid (n_valid),
    .stale   (stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic void pushEv(input int c, input int n, input bit s);
    ev_t e;
    e.cyc  = c;
    e.nclk = n;
    e.st   = s;
    evQ.push_back(e);
  endfunction

  function automatic void pushValid(input int c, input int v);
    sb_t s;
    s.cyc = c;
    s.val = v;
    sbQ.push_back(s);
    pushEv(c, v, 1'b0);
  endfunction

  // A newly measured period becomes visible LAT cycles after the rise that closes it.
  function automatic void publishPeriod(input int c, input int d);
`ifdef N_CLK_AVG_EN
    int sum;
    sum = 0;
    win.push_back(d);
    if (win.size() > (1 << AVG_LOG2)) void'(win.pop_front());
    if (win.size() == (1 << AVG_LOG2)) begin
      foreach (win[i]) sum += win[i];
      pushValid(c, sum >> AVG_LOG2);
    end
`else
    pushValid(c, d);
`endif
  endfunction

  function automatic void modelRise(input int k);
    if (!armed) begin
      armed    = 1'b1;
      lastRise = k;
    end else if (k - lastRise >= MINP) begin
      publishPeriod(k + LAT, k - lastRise);
      lastRise = k;
    end
  endfunction

  function automatic void modelTick(input int c);
    if (armed && (c - lastRise == MAXV)) begin
      armed = 1'b0;
      win.delete();
      pushEv(c + LAT, MAXV, 1'b1);
    end
  endfunction

  function automatic void modelReset(input int c);
    armed = 1'b0;
    win.delete();
    while (evQ.size() > 0 && evQ[evQ.size()-1].cyc >= c) void'(evQ.pop_back());
    while (sbQ.size() > 0 && sbQ[sbQ.size()-1].cyc >= c) void'(sbQ.pop_back());
    pushEv(c, MAXV, 1'b1);
    if (sig) begin
      armed    = 1'b1;
      lastRise = c;
    end
  endfunction

  task automatic tick(input logic v);
    logic prev;
    @(posedge clk);
    #1;
    prev = sig;
    sig  = v;
    if (v && !prev) modelRise(cyc);
    else modelTick(cyc);
  endtask

  // One rise at the start, high for highLen cycles, optional extra pulse, next rise after gap cycles.
  task automatic applyStimulus(input int gap, input int highLen, input int glitchAt, input int glitchLen);
    logic v;
    for (int i = 0; i < gap; i++) begin
      v = (i < highLen) || ((i >= glitchAt) && (i < glitchAt + glitchLen));
      tick(v);
    end
  endtask

  task automatic doReset(input logic holdHigh);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sig   = holdHigh;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset(cyc);
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      due = 1'b0;
      while (evQ.size() > 0 && evQ[0].cyc <= cyc) begin
        expN = evQ[0].nclk;
        expS = evQ[0].st;
        void'(evQ.pop_front());
        due = 1'b1;
      end
      if (evQ.size() > 0 && evQ[0].cyc == cyc + 1) due = 1'b1;
      if (n_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("n_valid_spurious", int'(n_valid), 0);
        end else begin
          checkOutput("n_valid_cycle", cyc, sbQ[0].cyc);
          checkOutput("n_valid_value", int'(n_clk), sbQ[0].val);
          void'(sbQ.pop_front());
          due = 1'b1;
        end
      end else if (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
        checkOutput("n_valid_missing", int'(n_valid), 1);
        void'(sbQ.pop_front());
      end
      if (due || (cyc % 64 == 0)) begin
        checkOutput("stale", int'(stale), int'(expS));
        checkOutput("n_clk", int'(n_clk), expN);
      end
    end
  end

  initial begin
    int gap;
    int hi;
    int gAt;
    int gLen;
    reset = 1'b1;
    sig   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    pushEv(cyc, MAXV, 1'b1);
    monOn = 1'b1;

    $display("[TB] square wave, period 1000");
    repeat (5) applyStimulus(1000, 500, 0, 0);

    $display("[TB] period 1000 with 5-cycle glitch 3 cycles after each edge");
    repeat (3) applyStimulus(1000, 2, 3, 5);

    $display("[TB] MIN_PERIOD boundary gaps");
    applyStimulus(MINP, 2, 0, 0);
    applyStimulus(MINP - 1, 2, 0, 0);
    applyStimulus(1000, 2, 0, 0);

    $display("[TB] randomised gaps and glitches");
    repeat (20) begin
      if ($urandom_range(0, 4) == 0) gap = $urandom_range(MINP - 1, MINP);
      else gap = $urandom_range(17, 1500);
      hi = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) begin
        gAt  = hi + 1 + $urandom_range(0, 5);
        gLen = $urandom_range(1, 4);
      end else begin
        gAt  = 0;
        gLen = 0;
      end
      applyStimulus(gap, hi, gAt, gLen);
    end

    $display("[TB] edges stop, then two edges re-arm");
    applyStimulus(16500, 2, 0, 0);
    applyStimulus(1000, 2, 0, 0);
    applyStimulus(1000, 2, 0, 0);

    $display("[TB] edge exactly N_CLK_MAX cycles after the previous one");
    applyStimulus(MAXV, 2, 0, 0);
    applyStimulus(1000, 2, 0, 0);

    $display("[TB] reset 400 cycles into a period");
    applyStimulus(400, 2, 0, 0);
    doReset(1'b0);
    repeat (3) applyStimulus(1000, 2, 0, 0);

    $display("[TB] reset released with sig high");
    doReset(1'b1);
    repeat (3) tick(1'b1);
    tick(1'b0);
    repeat (3) applyStimulus(1000, 2, 0, 0);

    repeat (20) tick(1'b0);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
